// File: rtl/sm83_wz_bus_sched.sv
// Sequencer and round-robin arbiter for the WZ output stage. It shares the stage's
// output paths between ABUS, DBUS_LO, DBUS_HI and IDU, and runs the PCH -> EVAL -> TURN phases.
module sm83_wz_bus_sched #(
    parameter int PCH_CYCLES  = 1,
    parameter int EVAL_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] sel_a_in,
    input  logic [3:0] sel_b_in,
    output logic [3:0] gnt,
    output logic       done,
    output logic       busy,
    output logic       pch_n,
    output logic       aoi_ena1,
    output logic       aoi_ena2,
    output logic       aoi_ena3,
    output logic       oai_ena1,
    output logic       oai_ena2,
    output logic       oai_ena3,
    output logic       nand_ena,
    output logic       muxi_a_sel,
    output logic       muxi_a_sel_n,
    output logic       muxi_b_sel,
    output logic       muxi_b_sel_n,
    output logic [1:0] dbg_state
);

    // Handshake: a requester holds req[i] level-high until it sees done while gnt[i] is set.
    // The arbiter samples req only in IDLE, and gnt stays set from PCH through the last EVAL cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PCH  = 2'd1,
        S_EVAL = 2'd2,
        S_TURN = 2'd3
    } state_t;

    localparam logic [1:0] PCH_LD  = 2'(PCH_CYCLES - 1);
    localparam logic [1:0] EVAL_LD = 2'(EVAL_CYCLES - 1);
    localparam logic [1:0] TURN_LD = 2'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic [3:0] gnt_q;
    logic       sel_a_q, sel_b_q;
    logic       start;
    logic       last_eval;
    logic       eval;

    // The round-robin search starts at the pointer, and the 2-bit index wraps naturally.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign start     = (state == S_IDLE) && found;
    assign last_eval = (state == S_EVAL) && (cnt == 2'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_PCH;
                    cnt_nxt   = PCH_LD;
                end
            end
            S_PCH: begin
                if (cnt == 2'd0) begin
                    state_nxt = S_EVAL;
                    cnt_nxt   = EVAL_LD;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            S_EVAL: begin
                if (cnt == 2'd0) begin
                    state_nxt = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
                    cnt_nxt   = TURN_LD;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            S_TURN: begin
                if (cnt == 2'd0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            ptr     <= 2'd0;
            gnt_q   <= 4'd0;
            sel_a_q <= 1'b0;
            sel_b_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                gnt_q   <= 4'b0001 << win;
                sel_a_q <= sel_a_in[win];
                sel_b_q <= sel_b_in[win];
                ptr     <= win + 2'd1;
            end else if (last_eval) begin
                gnt_q <= 4'd0;
            end
        end
    end

    // Enables decode only in EVAL, so they can never overlap precharge.
    assign eval         = (state == S_EVAL);
    assign gnt          = gnt_q;
    assign done         = last_eval;
    assign busy         = (state != S_IDLE);
    assign pch_n        = (state != S_PCH);
    assign aoi_ena1     = eval & gnt_q[0];
    assign aoi_ena2     = eval & gnt_q[1];
    assign oai_ena1     = eval & gnt_q[1];
    assign nand_ena     = eval & gnt_q[1];
    assign aoi_ena3     = eval & gnt_q[2];
    assign oai_ena2     = eval & gnt_q[2];
    assign oai_ena3     = eval & gnt_q[3];
    assign muxi_a_sel   = sel_a_q;
    assign muxi_a_sel_n = ~sel_a_q;
    assign muxi_b_sel   = sel_b_q;
    assign muxi_b_sel_n = ~sel_b_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_sm83_wz_bus_sched.sv
// Directed bench for sm83_wz_bus_sched. It instantiates three parameter sets:
// u0 = defaults, u1 = EVAL_CYCLES 3, u2 = PCH 2 / EVAL 2 / TURN 0.
module tb_sm83_wz_bus_sched;

    localparam int PCH_P  [3] = '{1, 1, 2};
    localparam int EVAL_P [3] = '{1, 3, 2};
    localparam int TURN_P [3] = '{1, 1, 0};
    // Enable bit order: {nand, oai3, oai2, oai1, aoi3, aoi2, aoi1}
    localparam logic [6:0] ENA_MAP [4] = '{7'b0000001, 7'b1001010, 7'b0010100, 7'b0100000};

    logic clk;
    logic reset_n;
    logic [2:0][3:0] req_a;
    logic [2:0][3:0] sel_a;
    logic [2:0][3:0] sel_b;
    logic [2:0][3:0] gnt_w;
    logic [2:0]      done_w;
    logic [2:0]      busy_w;
    logic [2:0]      pch_w;
    logic [2:0][6:0] ena_w;
    logic [2:0][3:0] mux_w;   // {a_sel, a_sel_n, b_sel, b_sel_n}
    logic [2:0][1:0] st_w;

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sm83_wz_bus_sched #(
            .PCH_CYCLES (PCH_P[g]),
            .EVAL_CYCLES(EVAL_P[g]),
            .TURN_CYCLES(TURN_P[g])
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .req         (req_a[g]),
            .sel_a_in    (sel_a[g]),
            .sel_b_in    (sel_b[g]),
            .gnt         (gnt_w[g]),
            .done        (done_w[g]),
            .busy        (busy_w[g]),
            .pch_n       (pch_w[g]),
            .aoi_ena1    (ena_w[g][0]),
            .aoi_ena2    (ena_w[g][1]),
            .aoi_ena3    (ena_w[g][2]),
            .oai_ena1    (ena_w[g][3]),
            .oai_ena2    (ena_w[g][4]),
            .oai_ena3    (ena_w[g][5]),
            .nand_ena    (ena_w[g][6]),
            .muxi_a_sel  (mux_w[g][3]),
            .muxi_a_sel_n(mux_w[g][2]),
            .muxi_b_sel  (mux_w[g][1]),
            .muxi_b_sel_n(mux_w[g][0]),
            .dbg_state   (st_w[g])
        );
    end

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        req_a   = '0;
        sel_a   = '0;
        sel_b   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_a   = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({pch_w[g], busy_w[g], done_w[g], gnt_w[g], ena_w[g]} !== {1'b1, 1'b0, 1'b0, 4'b0, 7'b0}) begin
                errors++;
                $display("FAIL reset_outputs u%0d: got pch_n=%b busy=%b done=%b gnt=%b ena=%b want 1 0 0 0000 0000000",
                         g, pch_w[g], busy_w[g], done_w[g], gnt_w[g], ena_w[g]);
            end
            checks++;
            if (mux_w[g] !== 4'b0101 || st_w[g] !== 2'd0) begin
                errors++;
                $display("FAIL reset_mux u%0d: got mux=%b state=%0d want 0101 0", g, mux_w[g], st_w[g]);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_abus();
        do_reset();
        req_a[0] = 4'b0001;
        @(negedge clk);
        checks++;
        if ({pch_w[0], busy_w[0], done_w[0], gnt_w[0], ena_w[0]} !== {1'b0, 1'b1, 1'b0, 4'b0001, 7'b0}) begin
            errors++;
            $display("FAIL single_pch: got pch_n=%b busy=%b done=%b gnt=%b ena=%b want 0 1 0 0001 0000000",
                     pch_w[0], busy_w[0], done_w[0], gnt_w[0], ena_w[0]);
        end
        @(negedge clk);
        checks++;
        if ({pch_w[0], done_w[0], gnt_w[0], ena_w[0]} !== {1'b1, 1'b1, 4'b0001, 7'b0000001}) begin
            errors++;
            $display("FAIL single_eval: got pch_n=%b done=%b gnt=%b ena=%b want 1 1 0001 0000001",
                     pch_w[0], done_w[0], gnt_w[0], ena_w[0]);
        end
        req_a[0] = 4'b0000;
        @(negedge clk);
        checks++;
        if ({pch_w[0], busy_w[0], done_w[0], gnt_w[0], ena_w[0]} !== {1'b1, 1'b1, 1'b0, 4'b0, 7'b0}) begin
            errors++;
            $display("FAIL single_turn: got pch_n=%b busy=%b done=%b gnt=%b ena=%b want 1 1 0 0000 0000000",
                     pch_w[0], busy_w[0], done_w[0], gnt_w[0], ena_w[0]);
        end
        @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b want 0", busy_w[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req_a[0] = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            @(negedge clk);
            checks++;
            if (gnt_w[0] !== exp_g) begin
                errors++;
                $display("FAIL rr_gnt_%0d: got %b want %b", k, gnt_w[0], exp_g);
            end
            @(negedge clk);
            checks++;
            if (ena_w[0] !== ENA_MAP[k] || done_w[0] !== 1'b1) begin
                errors++;
                $display("FAIL rr_ena_%0d: got ena=%b done=%b want %b 1", k, ena_w[0], done_w[0], ENA_MAP[k]);
            end
            repeat (2) @(negedge clk);
            if (k == 3) req_a[0] = 4'b0100;
        end
        @(negedge clk);
        checks++;
        if (gnt_w[0] !== 4'b0100) begin
            errors++;
            $display("FAIL rr_single_hi: got %b want 0100", gnt_w[0]);
        end
        @(negedge clk);
        checks++;
        if (ena_w[0] !== ENA_MAP[2]) begin
            errors++;
            $display("FAIL rr_single_hi_ena: got %b want %b", ena_w[0], ENA_MAP[2]);
        end
        req_a[0] = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_eval3_sel();
        do_reset();
        req_a[1] = 4'b0010;
        sel_a[1] = 4'b0010;
        sel_b[1] = 4'b1101;
        @(negedge clk);
        checks++;
        if (gnt_w[1] !== 4'b0010 || mux_w[1] !== 4'b1001 || pch_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL eval3_pch: got gnt=%b mux=%b pch_n=%b want 0010 1001 0", gnt_w[1], mux_w[1], pch_w[1]);
        end
        sel_a[1] = 4'b1101;
        sel_b[1] = 4'b0010;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            checks++;
            if (ena_w[1] !== 7'b1001010 || done_w[1] !== (e == 2) || pch_w[1] !== 1'b1) begin
                errors++;
                $display("FAIL eval3_cycle_%0d: got ena=%b done=%b pch_n=%b want 1001010 %0d 1",
                         e, ena_w[1], done_w[1], pch_w[1], (e == 2));
            end
        end
        req_a[1] = 4'b0000;
        @(negedge clk);
        checks++;
        if (ena_w[1] !== 7'b0 || mux_w[1] !== 4'b1001 || busy_w[1] !== 1'b1 || done_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL eval3_turn: got ena=%b mux=%b busy=%b done=%b want 0000000 1001 1 0",
                     ena_w[1], mux_w[1], busy_w[1], done_w[1]);
        end
        @(negedge clk);
        checks++;
        if (busy_w[1] !== 1'b0 || mux_w[1] !== 4'b1001) begin
            errors++;
            $display("FAIL eval3_idle: got busy=%b mux=%b want 0 1001", busy_w[1], mux_w[1]);
        end
    endtask

    task automatic test_reset_abort();
        int w;
        for (int n = 0; n < 2; n++) begin
            w = 3 - n;
            do_reset();
            req_a[1] = 4'b0001 << w;
            repeat (2) @(negedge clk);
            checks++;
            if (ena_w[1] !== ENA_MAP[w] || done_w[1] !== 1'b0) begin
                errors++;
                $display("FAIL abort_eval_%0d: got ena=%b done=%b want %b 0", w, ena_w[1], done_w[1], ENA_MAP[w]);
            end
            reset_n = 1'b0;
            @(negedge clk);
            checks++;
            if ({pch_w[1], busy_w[1], done_w[1], gnt_w[1], ena_w[1]} !== {1'b1, 1'b0, 1'b0, 4'b0, 7'b0}) begin
                errors++;
                $display("FAIL abort_after_%0d: got pch_n=%b busy=%b done=%b gnt=%b ena=%b want 1 0 0 0000 0000000",
                         w, pch_w[1], busy_w[1], done_w[1], gnt_w[1], ena_w[1]);
            end
            reset_n  = 1'b1;
            req_a[1] = 4'b1111;
            @(negedge clk);
            checks++;
            if (gnt_w[1] !== 4'b0001) begin
                errors++;
                $display("FAIL abort_ptr_%0d: got gnt=%b want 0001", w, gnt_w[1]);
            end
        end
        do_reset();
    endtask

    task automatic test_turn0_latency();
        do_reset();
        req_a[2] = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (pch_w[2] !== 1'b0 || ena_w[2] !== 7'b0 || gnt_w[2] !== 4'b0100) begin
                errors++;
                $display("FAIL t0_pch_%0d: got pch_n=%b ena=%b gnt=%b want 0 0000000 0100", c, pch_w[2], ena_w[2], gnt_w[2]);
            end
        end
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            checks++;
            if (ena_w[2] !== 7'b0010100 || done_w[2] !== (e == 1) || pch_w[2] !== 1'b1) begin
                errors++;
                $display("FAIL t0_eval_%0d: got ena=%b done=%b pch_n=%b want 0010100 %0d 1",
                         e, ena_w[2], done_w[2], pch_w[2], (e == 1));
            end
        end
        req_a[2] = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy_w[2] !== 1'b0 || st_w[2] !== 2'd0 || gnt_w[2] !== 4'b0) begin
            errors++;
            $display("FAIL t0_idle: got busy=%b state=%0d gnt=%b want 0 0 0000", busy_w[2], st_w[2], gnt_w[2]);
        end
    endtask

    task automatic test_random();
        int wait_c [4];
        int grants;
        int w;
        logic [3:0] prev_gnt;
        logic [3:0] prev_mux;
        do_reset();
        grants   = 0;
        prev_gnt = 4'b0;
        prev_mux = mux_w[2];
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            checks++;
            if (!pch_w[2] && ena_w[2] !== 7'b0) begin
                errors++;
                $display("FAIL rnd_pch_overlap cyc%0d: got ena=%b want 0000000", cyc, ena_w[2]);
            end
            checks++;
            if (mux_w[2][3] === mux_w[2][2] || mux_w[2][1] === mux_w[2][0] || !$onehot0(gnt_w[2])) begin
                errors++;
                $display("FAIL rnd_invariant cyc%0d: got mux=%b gnt=%b want complementary pairs, onehot0", cyc, mux_w[2], gnt_w[2]);
            end
            if (gnt_w[2] != 4'b0 && prev_gnt == 4'b0) begin
                grants++;
                w = 0;
                for (int i = 0; i < 4; i++) if (gnt_w[2][i]) w = i;
                checks++;
                if (req_a[2][w] !== 1'b1 || mux_w[2][3] !== sel_a[2][w] || mux_w[2][1] !== sel_b[2][w]) begin
                    errors++;
                    $display("FAIL rnd_grant cyc%0d: got gnt=%b req=%b mux=%b want req set, a=%b b=%b",
                             cyc, gnt_w[2], req_a[2], mux_w[2], sel_a[2][w], sel_b[2][w]);
                end
                for (int i = 0; i < 4; i++) begin
                    if (i == w) wait_c[i] = 0;
                    else if (req_a[2][i]) wait_c[i]++;
                end
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (wait_c[i] > 3) begin
                        errors++;
                        $display("FAIL rnd_starve cyc%0d: requester %0d waited %0d grants want <=3", cyc, i, wait_c[i]);
                    end
                end
            end else begin
                checks++;
                if (mux_w[2] !== prev_mux) begin
                    errors++;
                    $display("FAIL rnd_mux_hold cyc%0d: got %b want %b", cyc, mux_w[2], prev_mux);
                end
            end
            prev_gnt = gnt_w[2];
            prev_mux = mux_w[2];
            if (done_w[2]) req_a[2] = req_a[2] & ~gnt_w[2];
            for (int i = 0; i < 4; i++) begin
                if (!req_a[2][i] && $urandom_range(0, 3) == 0) req_a[2][i] = 1'b1;
            end
            sel_a[2] = 4'($urandom_range(0, 15));
            sel_b[2] = 4'($urandom_range(0, 15));
        end
        checks++;
        if (grants < 500) begin
            errors++;
            $display("FAIL rnd_activity: got %0d grants want >=500", grants);
        end
        do_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        req_a   = '0;
        sel_a   = '0;
        sel_b   = '0;
        test_reset();
        test_single_abus();
        test_round_robin();
        test_eval3_sel();
        test_reset_abort();
        test_turn0_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
